// File: rtl/surf_sram_arbiter.sv
// rtl/surf_sram_arbiter.sv - two-requester round-robin arbiter with bounded bursts for one SRAM port
// Core (C) and host (H) share port A; read data returns to the owner one cycle after the access.
module surf_sram_arbiter #(
  parameter int A_WIDTH   = 17,
  parameter int D_WIDTH   = 16,
  parameter int MAX_BURST = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               C_Req,
  input  logic               C_Wr,
  input  logic [A_WIDTH-1:0] C_Addr,
  input  logic [D_WIDTH-1:0] C_WData,
  output logic               C_Gnt,
  output logic               C_RValid,
  output logic [D_WIDTH-1:0] C_RData,
  input  logic               H_Req,
  input  logic               H_Wr,
  input  logic [A_WIDTH-1:0] H_Addr,
  input  logic [D_WIDTH-1:0] H_WData,
  output logic               H_Gnt,
  output logic               H_RValid,
  output logic [D_WIDTH-1:0] H_RData,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [D_WIDTH-1:0] M_Di,
  output logic               M_En,
  output logic               M_We,
  input  logic [D_WIDTH-1:0] M_Do
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_H} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          last_h, last_h_nxt;
  logic          c_acc, h_acc;
  logic          rd_c, rd_h;

  assign c_acc   = (state == OWN_C) && C_Req;
  assign h_acc   = (state == OWN_H) && H_Req;
  assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;

  always_comb begin
    M_En   = 1'b0;
    M_We   = 1'b0;
    M_Addr = '0;
    M_Di   = '0;
    if (c_acc) begin
      M_En   = 1'b1;
      M_We   = C_Wr;
      M_Addr = C_Addr;
      M_Di   = C_WData;
    end else if (h_acc) begin
      M_En   = 1'b1;
      M_We   = H_Wr;
      M_Addr = H_Addr;
      M_Di   = H_WData;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_h_nxt = last_h;
    case (state)
      IDLE: begin
        // On a tie the requester that did not own the port last goes first.
        if (C_Req && (!H_Req || last_h)) state_nxt = OWN_C;
        else if (H_Req)                  state_nxt = OWN_H;
      end
      OWN_C: begin
        if (!C_Req) begin
          state_nxt = H_Req ? OWN_H : IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (H_Req && (cnt_inc == MAX_CNT)) state_nxt = OWN_H;
        end
      end
      OWN_H: begin
        if (!H_Req) begin
          state_nxt = C_Req ? OWN_C : IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (C_Req && (cnt_inc == MAX_CNT)) state_nxt = OWN_C;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state == OWN_C)      last_h_nxt = 1'b0;
      else if (state == OWN_H) last_h_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_h <= 1'b1;
      rd_c   <= 1'b0;
      rd_h   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_h <= last_h_nxt;
      rd_c   <= c_acc && !C_Wr;
      rd_h   <= h_acc && !H_Wr;
    end
  end

  // Pending-read flags are tagged per requester, so a read issued just before a switch still returns to its issuer.
  assign C_Gnt    = (state == OWN_C);
  assign H_Gnt    = (state == OWN_H);
  assign C_RValid = rd_c;
  assign H_RValid = rd_h;
  assign C_RData  = rd_c ? M_Do : '0;
  assign H_RData  = rd_h ? M_Do : '0;

endmodule

// File: tb/tb_surf_sram_arbiter.sv
// tb/tb_surf_sram_arbiter.sv - scoreboard bench for surf_sram_arbiter
// Directed scenarios plus random traffic; a monitor checks every cycle against a rule-level model.
module tb_surf_sram_arbiter;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_wr = 1'b0, h_req = 1'b0, h_wr = 1'b0;
  logic [AW-1:0] c_addr = '0, h_addr = '0;
  logic [DW-1:0] c_wdata = '0, h_wdata = '0;
  logic          c_gnt, c_rvalid, h_gnt, h_rvalid, m_en, m_we;
  logic [DW-1:0] c_rdata, h_rdata, m_di;
  logic [DW-1:0] m_do = '0;
  logic [AW-1:0] m_addr;

  surf_sram_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .Clk(clk), .Rst(rst),
    .C_Req(c_req), .C_Wr(c_wr), .C_Addr(c_addr), .C_WData(c_wdata),
    .C_Gnt(c_gnt), .C_RValid(c_rvalid), .C_RData(c_rdata),
    .H_Req(h_req), .H_Wr(h_wr), .H_Addr(h_addr), .H_WData(h_wdata),
    .H_Gnt(h_gnt), .H_RValid(h_rvalid), .H_RData(h_rdata),
    .M_Addr(m_addr), .M_Di(m_di), .M_En(m_en), .M_We(m_we), .M_Do(m_do)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 17'h00010) return 16'hBEEF;
    return a[15:0] ^ 16'hC35A;
  endfunction

  // SRAM model driven only by the DUT's M_* pins.
  logic [DW-1:0] sram [int];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) sram[int'(m_addr)] = m_di;
      else      m_do <= sram.exists(int'(m_addr)) ? sram[int'(m_addr)] : init_val(m_addr);
    end
  end

  // Reference model and scoreboard.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_c[$], exp_h[$];
  int owner_m = 0, last_m = 2, run_m = 0, nxt_m = 0;
  logic pend_c = 1'b0, pend_h = 1'b0, acc_c, acc_h;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      owner_m = 0; last_m = 2; run_m = 0;
      pend_c = 1'b0; pend_h = 1'b0;
      exp_c.delete(); exp_h.delete();
      #1;
      chk("rst_gnt",    32'({c_gnt, h_gnt}), 32'd0);
      chk("rst_rvalid", 32'({c_rvalid, h_rvalid}), 32'd0);
      chk("rst_rdata",  32'({c_rdata, h_rdata}), 32'd0);
      chk("rst_mem",    32'({m_en, m_we}), 32'd0);
      chk("rst_maddr",  32'(m_addr), 32'd0);
    end else begin
      chk("c_gnt", 32'(c_gnt), 32'(owner_m == 1));
      chk("h_gnt", 32'(h_gnt), 32'(owner_m == 2));
      chk("one_gnt", 32'(c_gnt && h_gnt), 32'd0);
      chk("c_rvalid", 32'(c_rvalid), 32'(pend_c));
      chk("h_rvalid", 32'(h_rvalid), 32'(pend_h));
      if (c_rvalid) begin
        if (exp_c.size() == 0) chk("c_rdata_unexpected", 32'(c_rdata), 32'hFFFF_FFFF);
        else                   chk("c_rdata", 32'(c_rdata), 32'(exp_c.pop_front()));
      end else chk("c_rdata_idle", 32'(c_rdata), 32'd0);
      if (h_rvalid) begin
        if (exp_h.size() == 0) chk("h_rdata_unexpected", 32'(h_rdata), 32'hFFFF_FFFF);
        else                   chk("h_rdata", 32'(h_rdata), 32'(exp_h.pop_front()));
      end else chk("h_rdata_idle", 32'(h_rdata), 32'd0);

      acc_c = (owner_m == 1) && c_req;
      acc_h = (owner_m == 2) && h_req;
      if (acc_c || acc_h) begin
        chk("m_en", 32'(m_en), 32'd1);
        chk("m_we", 32'(m_we), 32'(acc_c ? c_wr : h_wr));
        chk("m_addr", 32'(m_addr), 32'(acc_c ? c_addr : h_addr));
        chk("m_di", 32'(m_di), 32'(acc_c ? c_wdata : h_wdata));
        if (acc_c) begin
          if (c_wr) ref_mem[int'(c_addr)] = c_wdata; else exp_c.push_back(ref_rd(c_addr));
        end else begin
          if (h_wr) ref_mem[int'(h_addr)] = h_wdata; else exp_h.push_back(ref_rd(h_addr));
        end
      end else begin
        chk("m_quiet", 32'({m_en, m_we}), 32'd0);
        chk("m_quiet_bus", 32'(m_addr) | 32'(m_di), 32'd0);
      end
      pend_c = acc_c && !c_wr;
      pend_h = acc_h && !h_wr;

      // Ownership rules: tie goes to the non-last owner, release on drop, forced release after MB accesses.
      nxt_m = owner_m;
      if (owner_m == 0) begin
        if (c_req && h_req) nxt_m = (last_m == 1) ? 2 : 1;
        else if (c_req)     nxt_m = 1;
        else if (h_req)     nxt_m = 2;
      end else begin
        if (!(owner_m == 1 ? c_req : h_req)) begin
          nxt_m = (owner_m == 1 ? h_req : c_req) ? 3 - owner_m : 0;
        end else begin
          run_m++;
          if ((owner_m == 1 ? h_req : c_req) && run_m >= MB) nxt_m = 3 - owner_m;
        end
      end
      if (nxt_m != owner_m) begin
        if (owner_m != 0) last_m = owner_m;
        run_m = 0;
      end
      owner_m = nxt_m;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_c();
    c_wr = 1'($urandom_range(0, 1));
    c_addr = AW'($urandom_range(0, 31)) | (AW'($urandom_range(0, 1)) << 16);
    c_wdata = DW'($urandom);
  endtask

  task automatic rand_h();
    h_wr = 1'($urandom_range(0, 1));
    h_addr = AW'($urandom_range(0, 31)) | (AW'($urandom_range(0, 1)) << 16);
    h_wdata = DW'($urandom);
  endtask

  int seq[$];
  int run_len[$], run_own[$];
  int bias;
  logic pc, ph;

  initial begin
    // Reset then idle
    tick(3);
    rst = 1'b0;
    tick(3);
    chk("idle_m_en", 32'(m_en), 32'd0);

    // Single core read of the preloaded word
    c_req = 1'b1; c_wr = 1'b0; c_addr = 17'h00010;
    tick(1);
    chk("single_gnt", 32'(c_gnt), 32'd1);
    chk("single_m_addr", 32'(m_addr), 32'h10);
    tick(1);
    c_req = 1'b0;
    chk("single_rvalid", 32'(c_rvalid), 32'd1);
    chk("single_rdata", 32'(c_rdata), 32'hBEEF);
    tick(3);

    // Simultaneous first request after reset
    rst = 1'b1; tick(1); rst = 1'b0;
    c_req = 1'b1; h_req = 1'b1; rand_c(); rand_h();
    tick(1);
    chk("tie_core_first", 32'({c_gnt, h_gnt}), 32'b10);
    tick(1);
    c_req = 1'b0;
    tick(1);
    chk("tie_host_next", 32'({c_gnt, h_gnt}), 32'b01);
    h_req = 1'b0;
    tick(3);

    // Burst fairness: both requesters hold Req continuously
    c_req = 1'b1; h_req = 1'b1; rand_c(); rand_h();
    repeat (70) begin
      pc = c_gnt && c_req; ph = h_gnt && h_req;
      tick(1);
      seq.push_back(c_gnt ? 1 : (h_gnt ? 2 : 0));
      if (pc) rand_c();
      if (ph) rand_h();
    end
    c_req = 1'b0; h_req = 1'b0;
    tick(3);
    foreach (seq[i]) begin
      if (seq[i] == 0) continue;
      if (run_own.size() > 0 && run_own[$] == seq[i]) run_len[$] = run_len[$] + 1;
      else begin run_own.push_back(seq[i]); run_len.push_back(1); end
    end
    chk("burst_runs", 32'(run_len.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < run_len.size(); i++) begin
      chk("burst_len", 32'(run_len[i]), 32'(MB));
      chk("burst_owner", 32'(run_own[i]), 32'((i % 2) + 1));
    end

    // Switch with a read pending from the outgoing owner
    c_req = 1'b1; c_wr = 1'b0; c_addr = 17'd1;
    tick(1);
    h_req = 1'b1; h_wr = 1'b1; h_addr = 17'h00003; h_wdata = 16'h1234;
    for (int k = 2; k <= MB; k++) begin
      tick(1);
      c_addr = (k == MB) ? 17'h1FFFF : AW'(k);
    end
    tick(1);
    chk("sw_gnt", 32'({c_gnt, h_gnt}), 32'b01);
    chk("sw_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("sw_c_rdata", 32'(c_rdata), 32'(init_val(17'h1FFFF)));
    chk("sw_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("sw_m_we", 32'(m_we), 32'd1);
    chk("sw_m_di", 32'(m_di), 32'h1234);
    c_req = 1'b0;
    tick(1);
    h_req = 1'b0;
    tick(3);

    // Async reset mid-burst with a host read outstanding
    h_req = 1'b1; h_wr = 1'b0; h_addr = 17'd5;
    tick(2);
    chk("ar_pre_rvalid", 32'(h_rvalid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_h_gnt", 32'(h_gnt), 32'd0);
    chk("ar_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("ar_m_en", 32'(m_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; h_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 17'd7;
    tick(1);
    chk("ar_c_gnt", 32'(c_gnt), 32'd1);
    c_req = 1'b0;
    tick(3);

    // Random traffic, heavy contention first then sparse
    for (int cyc = 0; cyc < 2500; cyc++) begin
      bias = (cyc < 1200) ? 9 : 4;
      @(negedge clk);
      pc = c_gnt && c_req; ph = h_gnt && h_req;
      @(posedge clk);
      #1;
      if (pc || !c_req) begin
        if ($urandom_range(0, 9) < bias) begin c_req = 1'b1; rand_c(); end
        else c_req = 1'b0;
      end
      if (ph || !h_req) begin
        if ($urandom_range(0, 9) < bias) begin h_req = 1'b1; rand_h(); end
        else h_req = 1'b0;
      end
    end
    c_req = 1'b0; h_req = 1'b0;
    tick(5);
    chk("c_queue_drained", 32'(exp_c.size()), 32'd0);
    chk("h_queue_drained", 32'(exp_h.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/surf_sram_arbiter.md
Name: surf_sram_arbiter

Overview:
- Two-requester arbiter for one port of a SURF dual-port SRAM (dp_sram_coregen, port A).
- Requester C is the determinant core; requester H is the host loader/debug path.
- Round-robin with a bounded burst hold. Only the granted requester reaches the SRAM.
- Read data returns to the owner with fixed 1-cycle SRAM latency.

Parameters:
A_WIDTH, 17, SRAM address width
D_WIDTH, 16, SRAM data width
MAX_BURST, 16, max consecutive accesses by one owner while the other requests (power of two, >=2)

Ports:
Clk  in  1  single system clock, rising edge
Rst  in  1  asynchronous reset, active-high
C_Req  in  1  core access request; one access per cycle while granted
C_Wr  in  1  1=write, 0=read
C_Addr  in  A_WIDTH  core address
C_WData  in  D_WIDTH  core write data
C_Gnt  out  1  core owns SRAM port
C_RValid  out  1  core read data valid
C_RData  out  D_WIDTH  core read data
H_Req, H_Wr, H_Addr, H_WData  in  1/1/A_WIDTH/D_WIDTH  host equivalents
H_Gnt, H_RValid  out  1  host equivalents
H_RData  out  D_WIDTH  host read data
M_Addr  out  A_WIDTH  SRAM address
M_Di  out  D_WIDTH  SRAM write data
M_En  out  1  SRAM enable
M_We  out  1  SRAM write enable
M_Do  in  D_WIDTH  SRAM read data (valid cycle after read enable)

Behaviour:
- States: IDLE, OWN_C, OWN_H. C_Gnt = (state==OWN_C), H_Gnt = (state==OWN_H). Both are registered and never high together.
- Reset (async, Rst=1): state=IDLE, burst counter=0, last_owner=H (core wins first tie), pending-read flags=0. All outputs 0.
- Access rule: an access occurs in any cycle where the owner's Gnt=1 and Req=1.
  - M_En=1, M_We=owner Wr, M_Addr/M_Di = owner Addr/WData (combinational mux).
  - Otherwise M_En=0, M_We=0, M_Addr=0, M_Di=0.
  - Req during a cycle without Gnt performs no access. Requesters hold Req/Addr/Wr/WData until they see Gnt.
- IDLE:
  - Only C_Req → OWN_C next cycle. Only H_Req → OWN_H.
  - Both → the requester not equal to last_owner.
  - Neither → stay. Grant latency from Req rise in IDLE is exactly 1 cycle.
- OWN_x:
  - Each access increments the burst counter.
  - Owner drops Req → release next cycle: go to OWN_other if other Req=1, else IDLE.
  - Counter reaches MAX_BURST accesses with other Req=1 → forced release; OWN_other next cycle.
  - With other Req=0, the counter saturates and the owner keeps the grant.
  - On any state change: counter cleared, last_owner = released owner.
- Read return: a read access at cycle t gives owner RValid=1 at t+1, RData=M_Do at t+1.
  - A read in the final cycle before a grant switch still returns to the original owner.
  - The non-owner's RValid stays 0. RData is 0 when its RValid=0.
- Writes produce no RValid.
- Arithmetic: burst counter is clog2(MAX_BURST)+1 bits, unsigned. No address arithmetic; addresses pass through unmodified.
- Rst mid-burst: grant drops immediately (async). Pending RValid is cleared. The in-flight SRAM read is discarded.
- No combinational path from Req to Gnt. M_* depend combinationally on owner Req/Addr/Wr/WData.

Test Plan:
- Reset then idle: Rst pulse 3 cycles, no Req → all outputs 0, M_En=0 throughout.
- Single core read: C_Req=1, C_Wr=0, C_Addr=0x00010 at cycle 1 → C_Gnt=1 at cycle 2. M_En=1, M_Addr=0x00010 at cycle 2. Model M_Do=0xBEEF → C_RValid=1, C_RData=0xBEEF at cycle 3.
- Simultaneous first request: C_Req and H_Req rise together after reset → core granted first (C_Gnt=1, H_Gnt=0). After core drops Req, H_Gnt=1 next cycle with no IDLE bubble.
- Burst fairness: both hold Req continuously, MAX_BURST=16 → core makes 16 accesses, then host makes 16, alternating. No cycle with both Gnt high. No access lost or duplicated; scoreboard address sequences.
- Switch with pending read: core's last access is a read of 0x1FFFF, then the grant switches to a host write 0x0003 → 0x1234. C_RValid=1 with M_Do in the host's first grant cycle, H_RValid=0, M_We=1, M_Di=0x1234.
- Async reset mid-burst: assert Rst between clock edges during OWN_H with a read outstanding → H_Gnt, H_RValid, M_En fall immediately. After release with only C_Req=1, C_Gnt=1 one cycle later.
